pw_match_sequencer: RTL and testbench

Sequences up to pSTAGES pw pattern matcher instances into a multi-stage trigger chain. Only the current stage is armed. Each stage must match within a programmable window of the previous match, otherwise the chain restarts at stage 0. A match on the final stage emits a one-cycle trigger, then the block holds off and either re-arms or parks. Sits between the register block and the matcher instances, and feeds the trigger block; fe_clk domain only.

---
 rtl/pw_match_sequencer.sv | 147 ++++++++++++++
 tb/tb_pw_match_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pw_match_sequencer.sv
// pw_match_sequencer: multi-stage pw matcher trigger chain with inter-stage windows and holdoff/re-arm.
// Optional elapsed-cycle measurement is built when PW_MATCH_SEQ_ELAPSED_EN is defined.
module pw_match_sequencer #(
    parameter int pSTAGES      = 4,
    parameter int pWINDOW_BITS = 16
) (
    input  logic                    fe_clk,
    input  logic                    reset_i,
    input  logic                    I_enable,
    input  logic [2:0]              I_stages,
    input  logic [pWINDOW_BITS-1:0] I_window,
    input  logic [15:0]             I_holdoff,
    input  logic                    I_rearm,
    input  logic [pSTAGES-1:0]      I_stage_match,
    output logic [pSTAGES-1:0]      O_stage_arm,
    output logic [pSTAGES-1:0]      O_stage_clear,
    output logic                    O_trigger,
    output logic [2:0]              O_state,
    output logic [2:0]              O_current_stage,
    output logic [7:0]              O_timeout_count,
    output logic [15:0]             O_trigger_count,
    output logic [15:0]             O_elapsed
);
    typedef enum logic [2:0] {IDLE = 3'd0, CLEAR = 3'd1, ARMED = 3'd2, HOLDOFF = 3'd3, DONE = 3'd4} state_t;
    localparam logic [2:0] MAX_STAGES = 3'(pSTAGES);
    state_t                  state, state_n;
    logic [2:0]              stage, stage_n, n_stages, n_stages_n;
    logic [pWINDOW_BITS-1:0] window, window_n, wcnt, wcnt_n;
    logic [15:0]             hcnt, hcnt_n;
    logic [pSTAGES-1:0]      arm_n, clear_n;
    logic                    trig_n;
    logic [7:0]              tout_n;
    logic [15:0]             tcnt_n;
    logic                    hit, last, expire, hold_last;
    // O_stage_arm is one-hot on the current stage while ARMED, so it doubles as the match select
    assign hit       = (state == ARMED) && |(I_stage_match & O_stage_arm);
    assign last      = stage == n_stages - 3'd1;
    assign expire    = (stage != 3'd0) && (window != '0) && (wcnt + pWINDOW_BITS'(1) == window);
    assign hold_last = {1'b0, hcnt} + 17'd1 >= {1'b0, I_holdoff};
    assign O_state         = state;
    assign O_current_stage = stage;
    always_comb begin
        state_n    = state;
        stage_n    = stage;
        n_stages_n = n_stages;
        window_n   = window;
        wcnt_n     = '0;
        hcnt_n     = '0;
        arm_n      = '0;
        clear_n    = '0;
        trig_n     = 1'b0;
        tout_n     = O_timeout_count;
        tcnt_n     = O_trigger_count;
        if (!I_enable) begin
            state_n = IDLE;
            stage_n = 3'd0;
            clear_n = (state == IDLE) ? '0 : '1;
        end else begin
            case (state)
                IDLE: begin
                    state_n = CLEAR;
                    stage_n = 3'd0;
                    clear_n = '1;
                end
                CLEAR: begin
                    state_n    = ARMED;
                    stage_n    = 3'd0;
                    n_stages_n = (I_stages == 3'd0) ? 3'd1 : (I_stages > MAX_STAGES) ? MAX_STAGES : I_stages;
                    window_n   = I_window;
                    arm_n      = pSTAGES'(1);
                end
                ARMED: begin
                    if (hit && last) begin
                        state_n = HOLDOFF;
                        stage_n = 3'd0;
                        trig_n  = 1'b1;
                        tcnt_n  = O_trigger_count + 16'd1;
                        clear_n = '1;
                    end else if (hit) begin
                        stage_n = stage + 3'd1;
                        clear_n = O_stage_arm;
                        arm_n   = O_stage_arm << 1;
                    end else if (expire) begin
                        state_n = CLEAR;
                        stage_n = 3'd0;
                        clear_n = '1;
                        tout_n  = O_timeout_count + {7'd0, O_timeout_count != 8'hFF};
                    end else begin
                        arm_n  = O_stage_arm;
                        wcnt_n = (stage != 3'd0) ? wcnt + pWINDOW_BITS'(1) : '0;
                    end
                end
                HOLDOFF: begin
                    state_n = hold_last ? (I_rearm ? CLEAR : DONE) : HOLDOFF;
                    clear_n = (hold_last && I_rearm) ? '1 : '0;
                    hcnt_n  = hold_last ? '0 : hcnt + 16'd1;
                end
                DONE: state_n = DONE;
                default: state_n = IDLE;
            endcase
        end
    end
    always_ff @(posedge fe_clk) begin
        if (reset_i) begin
            state           <= IDLE;
            stage           <= 3'd0;
            n_stages        <= 3'd1;
            window          <= '0;
            wcnt            <= '0;
            hcnt            <= '0;
            O_stage_arm     <= '0;
            O_stage_clear   <= '0;
            O_trigger       <= 1'b0;
            O_timeout_count <= '0;
            O_trigger_count <= '0;
        end else begin
            state           <= state_n;
            stage           <= stage_n;
            n_stages        <= n_stages_n;
            window          <= window_n;
            wcnt            <= wcnt_n;
            hcnt            <= hcnt_n;
            O_stage_arm     <= arm_n;
            O_stage_clear   <= clear_n;
            O_trigger       <= trig_n;
            O_timeout_count <= tout_n;
            O_trigger_count <= tcnt_n;
        end
    end
`ifdef PW_MATCH_SEQ_ELAPSED_EN
    logic [15:0] ecnt, ecnt_inc;
    assign ecnt_inc = (ecnt == 16'hFFFF) ? ecnt : ecnt + 16'd1;
    always_ff @(posedge fe_clk) begin
        if (reset_i) begin
            ecnt      <= '0;
            O_elapsed <= '0;
        end else begin
            if (state == ARMED)
                ecnt <= (hit && stage == 3'd0) ? '0 : ecnt_inc;
            if (trig_n)
                O_elapsed <= (n_stages == 3'd1) ? '0 : ecnt_inc;
        end
    end
`else
    assign O_elapsed = '0;
`endif
endmodule

// File: tb/tb_pw_match_sequencer.sv
// tb_pw_match_sequencer: directed scenarios plus randomized run against a deadline-based reference model.
module tb_pw_match_sequencer;
    localparam int S = 4;
`ifdef PW_MATCH_SEQ_ELAPSED_EN
    localparam bit EL = 1'b1;
`else
    localparam bit EL = 1'b0;
`endif
    logic fe_clk = 1'b0, reset_i = 1'b1, en = 1'b0, rearm = 1'b0;
    logic [2:0] stages = 3'd1;
    logic [15:0] window = '0, holdoff = '0;
    logic [S-1:0] match = '0;
    logic [S-1:0] arm, clr;
    logic trig;
    logic [2:0] st, cur;
    logic [7:0] tocnt;
    logic [15:0] tcnt, elapsed;
    int total = 0, bad = 0;
    longint cyc = 0;
    int ms = 0, mk = 0, mlat = 1, m_tcnt = 0, m_tocnt = 0, m_elapsed = 0;
    longint mwin = 0, deadline = 0, hold_end = 0, s0 = 0;
    logic [S-1:0] m_clr = '0;
    logic m_trig = 1'b0;

    pw_match_sequencer #(.pSTAGES(S), .pWINDOW_BITS(16)) dut (
        .fe_clk(fe_clk), .reset_i(reset_i), .I_enable(en), .I_stages(stages), .I_window(window),
        .I_holdoff(holdoff), .I_rearm(rearm), .I_stage_match(match), .O_stage_arm(arm),
        .O_stage_clear(clr), .O_trigger(trig), .O_state(st), .O_current_stage(cur),
        .O_timeout_count(tocnt), .O_trigger_count(tcnt), .O_elapsed(elapsed)
    );

    always #5 fe_clk = ~fe_clk;

    // Reference model: stage windows and holdoff tracked as absolute cycle deadlines.
    task automatic model_step();
        m_trig = 1'b0;
        m_clr  = '0;
        if (reset_i) begin
            ms = 0; mk = 0; m_tcnt = 0; m_tocnt = 0; m_elapsed = 0;
        end else if (!en) begin
            if (ms != 0) m_clr = '1;
            ms = 0; mk = 0;
        end else if (ms == 0) begin
            ms = 1; m_clr = '1;
        end else if (ms == 1) begin
            mlat = (stages == 3'd0) ? 1 : (int'(stages) > S) ? S : int'(stages);
            mwin = longint'(window);
            ms = 2; mk = 0;
        end else if (ms == 2) begin
            if (((match >> mk) & 4'd1) != 4'd0) begin
                if (mk == 0) s0 = cyc;
                if (mk == mlat - 1) begin
                    ms = 3; m_trig = 1'b1; m_tcnt++; m_clr = '1;
                    hold_end = cyc + ((holdoff == 16'd0) ? 1 : longint'(holdoff));
                    m_elapsed = (mlat == 1) ? 0 : ((cyc - s0 > 65535) ? 65535 : int'(cyc - s0));
                    mk = 0;
                end else begin
                    m_clr = 4'(1 << mk);
                    mk++;
                    deadline = cyc + 1 + mwin;
                end
            end else if (mk > 0 && mwin != 0 && cyc + 1 == deadline) begin
                ms = 1; mk = 0; m_clr = '1;
                if (m_tocnt < 255) m_tocnt++;
            end
        end else if (ms == 3) begin
            if (cyc == hold_end) begin
                ms = rearm ? 1 : 4;
                if (rearm) m_clr = '1;
            end
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge fe_clk);
        #1;
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset();
        reset_i = 1'b1; en = 1'b0; match = '0;
        cycle(); cycle();
        reset_i = 1'b0;
    endtask

    task automatic test_reset();
        reset_i = 1'b1; en = 1'b1; match = '1;
        cycle(); cycle();
        total++; if (st !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", st); end
        total++; if (arm !== 4'h0) begin bad++; $display("FAIL reset_arm got=%h exp=0", arm); end
        total++; if (clr !== 4'h0) begin bad++; $display("FAIL reset_clear got=%h exp=0", clr); end
        total++; if (trig !== 1'b0) begin bad++; $display("FAIL reset_trigger got=%b exp=0", trig); end
        total++; if (cur !== 3'd0) begin bad++; $display("FAIL reset_stage got=%0d exp=0", cur); end
        total++; if (tocnt !== 8'd0 || tcnt !== 16'd0) begin bad++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", tocnt, tcnt); end
        total++; if (elapsed !== 16'd0) begin bad++; $display("FAIL reset_elapsed got=%0d exp=0", elapsed); end
        reset_i = 1'b0; en = 1'b0; match = '0;
    endtask

    task automatic test_three_stage();
        do_reset();
        stages = 3'd3; window = 16'd100; rearm = 1'b0; holdoff = 16'd4; en = 1'b1;
        cycle();
        total++; if (st !== 3'd1 || clr !== 4'hF) begin bad++; $display("FAIL chain_clear got st=%0d clr=%h exp st=1 clr=f", st, clr); end
        cycle();
        total++; if (st !== 3'd2 || arm !== 4'b0001) begin bad++; $display("FAIL chain_arm0 got st=%0d arm=%b exp st=2 arm=0001", st, arm); end
        match = 4'b0001; cycle(); match = '0;
        total++; if (arm !== 4'b0010 || clr !== 4'b0001 || cur !== 3'd1) begin bad++; $display("FAIL chain_adv1 got arm=%b clr=%b cur=%0d exp 0010/0001/1", arm, clr, cur); end
        run(9);
        match = 4'b0010; cycle(); match = '0;
        total++; if (arm !== 4'b0100 || clr !== 4'b0010 || cur !== 3'd2) begin bad++; $display("FAIL chain_adv2 got arm=%b clr=%b cur=%0d exp 0100/0010/2", arm, clr, cur); end
        run(9);
        total++; if (trig !== 1'b0) begin bad++; $display("FAIL chain_early_trig got=%b exp=0", trig); end
        match = 4'b0100; cycle(); match = '0;
        total++; if (trig !== 1'b1 || tcnt !== 16'd1 || arm !== 4'h0 || st !== 3'd3) begin bad++; $display("FAIL chain_trigger got trig=%b cnt=%0d arm=%b st=%0d exp 1/1/0000/3", trig, tcnt, arm, st); end
        cycle();
        total++; if (trig !== 1'b0) begin bad++; $display("FAIL chain_pulse_width got=%b exp=0", trig); end
        run(3);
        total++; if (st !== 3'd4) begin bad++; $display("FAIL chain_done got=%0d exp=4", st); end
        run(5);
        total++; if (st !== 3'd4 || tcnt !== 16'd1) begin bad++; $display("FAIL chain_park got st=%0d cnt=%0d exp 4/1", st, tcnt); end
    endtask

    task automatic test_timeout();
        do_reset();
        stages = 3'd2; window = 16'd5; rearm = 1'b0; en = 1'b1;
        cycle(); cycle();
        match = 4'b0001; cycle(); match = '0;
        run(4);
        total++; if (st !== 3'd2 || arm !== 4'b0010) begin bad++; $display("FAIL timeout_early got st=%0d arm=%b exp 2/0010", st, arm); end
        cycle();
        total++; if (st !== 3'd1 || tocnt !== 8'd1 || clr !== 4'hF) begin bad++; $display("FAIL timeout_fire got st=%0d cnt=%0d clr=%h exp 1/1/f", st, tocnt, clr); end
        cycle();
        total++; if (st !== 3'd2 || arm !== 4'b0001) begin bad++; $display("FAIL timeout_rearm got st=%0d arm=%b exp 2/0001", st, arm); end
    endtask

    task automatic test_window_edge();
        do_reset();
        stages = 3'd2; window = 16'd5; rearm = 1'b0; en = 1'b1;
        cycle(); cycle();
        match = 4'b0001; cycle(); match = '0;
        run(4);
        match = 4'b0010; cycle(); match = '0;
        total++; if (trig !== 1'b1 || tocnt !== 8'd0 || st !== 3'd3) begin bad++; $display("FAIL window_edge got trig=%b to=%0d st=%0d exp 1/0/3", trig, tocnt, st); end
    endtask

    task automatic test_rearm();
        do_reset();
        stages = 3'd1; window = 16'd0; holdoff = 16'd20; rearm = 1'b1; en = 1'b1;
        cycle(); cycle();
        match = 4'b0001; cycle();
        total++; if (trig !== 1'b1 || tcnt !== 16'd1) begin bad++; $display("FAIL rearm_first got trig=%b cnt=%0d exp 1/1", trig, tcnt); end
        for (int i = 0; i < 20; i++) begin
            match = (i < 10) ? 4'b0001 : 4'b0000;
            cycle();
            total++; if (trig !== 1'b0 || tcnt !== 16'd1) begin bad++; $display("FAIL rearm_holdoff_ignore got trig=%b cnt=%0d exp 0/1", trig, tcnt); end
        end
        total++; if (st !== 3'd1) begin bad++; $display("FAIL rearm_clear got=%0d exp=1", st); end
        match = '0; cycle();
        total++; if (st !== 3'd2 || arm !== 4'b0001) begin bad++; $display("FAIL rearm_armed got st=%0d arm=%b exp 2/0001", st, arm); end
        match = 4'b0001; cycle(); match = '0;
        total++; if (trig !== 1'b1 || tcnt !== 16'd2) begin bad++; $display("FAIL rearm_second got trig=%b cnt=%0d exp 1/2", trig, tcnt); end
    endtask

    task automatic test_abort();
        do_reset();
        stages = 3'd2; window = 16'd0; rearm = 1'b0; en = 1'b1;
        cycle(); cycle();
        match = 4'b0001; cycle();
        match = 4'b0010; en = 1'b0; cycle();
        total++; if (trig !== 1'b0 || tcnt !== 16'd0) begin bad++; $display("FAIL abort_trigger got trig=%b cnt=%0d exp 0/0", trig, tcnt); end
        total++; if (st !== 3'd0 || arm !== 4'h0 || clr !== 4'hF) begin bad++; $display("FAIL abort_state got st=%0d arm=%b clr=%h exp 0/0000/f", st, arm, clr); end
        match = '0; cycle();
        total++; if (clr !== 4'h0 || st !== 3'd0) begin bad++; $display("FAIL abort_clear_width got clr=%h st=%0d exp 0/0", clr, st); end
    endtask

    task automatic test_elapsed();
        do_reset();
        stages = 3'd2; window = 16'd0; rearm = 1'b0; holdoff = 16'd1; en = 1'b1;
        cycle(); cycle();
        match = 4'b0001; cycle(); match = '0;
        run(36);
        match = 4'b0010; cycle(); match = '0;
        total++; if (trig !== 1'b1) begin bad++; $display("FAIL elapsed_trigger got=%b exp=1", trig); end
        total++; if (elapsed !== (EL ? 16'd37 : 16'd0)) begin bad++; $display("FAIL elapsed_value got=%0d exp=%0d", elapsed, EL ? 37 : 0); end
    endtask

    task automatic test_random();
        do_reset();
        holdoff = 16'($urandom_range(0, 6));
        for (int i = 0; i < 3000; i++) begin
            reset_i = ($urandom_range(0, 699) == 0);
            en      = ($urandom_range(0, 59) != 0);
            rearm   = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) == 0) stages = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) window = 16'($urandom_range(0, 8));
            match = 4'($urandom) & 4'($urandom);
            cycle();
            total++; if (st !== 3'(ms)) begin bad++; $display("FAIL rnd_state cyc=%0d got=%0d exp=%0d", cyc, st, ms); end
            total++; if (cur !== 3'(mk)) begin bad++; $display("FAIL rnd_stage cyc=%0d got=%0d exp=%0d", cyc, cur, mk); end
            total++; if (arm !== ((ms == 2) ? 4'(1 << mk) : 4'h0)) begin bad++; $display("FAIL rnd_arm cyc=%0d got=%b exp=%b", cyc, arm, (ms == 2) ? 4'(1 << mk) : 4'h0); end
            total++; if (clr !== m_clr) begin bad++; $display("FAIL rnd_clear cyc=%0d got=%b exp=%b", cyc, clr, m_clr); end
            total++; if (trig !== m_trig) begin bad++; $display("FAIL rnd_trigger cyc=%0d got=%b exp=%b", cyc, trig, m_trig); end
            total++; if (tcnt !== 16'(m_tcnt)) begin bad++; $display("FAIL rnd_trig_count cyc=%0d got=%0d exp=%0d", cyc, tcnt, m_tcnt); end
            total++; if (tocnt !== 8'(m_tocnt)) begin bad++; $display("FAIL rnd_timeout_count cyc=%0d got=%0d exp=%0d", cyc, tocnt, m_tocnt); end
            total++; if (elapsed !== (EL ? 16'(m_elapsed) : 16'd0)) begin bad++; $display("FAIL rnd_elapsed cyc=%0d got=%0d exp=%0d", cyc, elapsed, EL ? m_elapsed : 0); end
        end
        reset_i = 1'b0; en = 1'b0; match = '0;
    endtask

    initial begin
        test_reset();
        test_three_stage();
        test_timeout();
        test_window_edge();
        test_rearm();
        test_abort();
        test_elapsed();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
